// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply datapath.
// Used by the address sequencer, dram_control and the MAC unit.
package matmul_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_A     = 3'd1,
      RD_B     = 3'd2,
      WAIT_MAC = 3'd3,
      WR_C     = 3'd4,
      DONE     = 3'd5
   } state_t;

   localparam int         DEFAULT_ADDR_W = 8;
   localparam logic [7:0] DEFAULT_A_BASE = 8'h00;
   localparam logic [7:0] DEFAULT_B_BASE = 8'h40;
   localparam logic [7:0] DEFAULT_C_BASE = 8'h80;

endpackage

// File: rtl/matmul_addr_seq_if.sv
// Control and address bus between the address sequencer and its consumers
// (dram_control, MAC unit, and the block that issues start).
interface matmul_addr_seq_if
   import matmul_pkg::*;
#(
   parameter int ADDR_W = DEFAULT_ADDR_W
);
   logic              start;
   logic              stall;
   logic              mac_done;
   logic [ADDR_W-1:0] address;
   logic              write_en;
   logic              rd_valid;
   logic              operand_sel;
   logic              acc_clear;
   logic              k_last;
   logic              busy;
   logic              done;

   modport master (
      input  start, stall, mac_done,
      output address, write_en, rd_valid, operand_sel, acc_clear, k_last, busy, done
   );

   modport slave (
      output start, stall, mac_done,
      input  address, write_en, rd_valid, operand_sel, acc_clear, k_last, busy, done
   );
endinterface

// File: rtl/matmul_idx_counter.sv
// Nested i/j/k index counter: k is the dot-product index, j the column and
// i the row of the output element. Each index wraps at exactly N-1.
module matmul_idx_counter #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_k,
   input  logic             inc_ij,
   input  logic             clr,
   output logic [IDX_W-1:0] i,
   output logic [IDX_W-1:0] j,
   output logic [IDX_W-1:0] k,
   output logic             k_last,
   output logic             ij_last
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

   assign k_last  = (k == LAST);
   assign ij_last = (i == LAST) && (j == LAST);

   // Advancing to the next element always restarts the dot product at k=0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i <= '0;
         j <= '0;
         k <= '0;
      end else if (clr) begin
         i <= '0;
         j <= '0;
         k <= '0;
      end else if (inc_ij) begin
         k <= '0;
         if (j == LAST) begin
            j <= '0;
            i <= (i == LAST) ? '0 : i + IDX_W'(1);
         end else begin
            j <= j + IDX_W'(1);
         end
      end else if (inc_k) begin
         k <= (k == LAST) ? '0 : k + IDX_W'(1);
      end
   end

endmodule

// File: rtl/matmul_addr_seq.sv
// Address sequencer for C = A x B: interleaved A-row/B-column operand reads,
// a wait for the MAC result, then one write of each C element.
module matmul_addr_seq
   import matmul_pkg::*;
#(
   parameter int                N      = 4,
   parameter int                ADDR_W = DEFAULT_ADDR_W,
   parameter logic [ADDR_W-1:0] A_BASE = ADDR_W'(DEFAULT_A_BASE),
   parameter logic [ADDR_W-1:0] B_BASE = ADDR_W'(DEFAULT_B_BASE),
   parameter logic [ADDR_W-1:0] C_BASE = ADDR_W'(DEFAULT_C_BASE)
)(
   input  logic                clk,
   input  logic                rst,
   matmul_addr_seq_if.master   bus
);

   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   state_t            state, next_state;
   logic [IDX_W-1:0]  i, j, k;
   logic              k_at_last, ij_at_last;
   logic              inc_k, inc_ij, clr;
   logic [ADDR_W-1:0] i_a, j_a, k_a, n_a;
   logic [ADDR_W-1:0] a_addr, b_addr, c_addr;

   matmul_idx_counter #(
      .N     (N),
      .IDX_W (IDX_W)
   ) u_idx (
      .clk     (clk),
      .rst     (rst),
      .inc_k   (inc_k),
      .inc_ij  (inc_ij),
      .clr     (clr),
      .i       (i),
      .j       (j),
      .k       (k),
      .k_last  (k_at_last),
      .ij_last (ij_at_last)
   );

   // Row-major addressing; products and sums wrap at ADDR_W bits
   assign i_a    = ADDR_W'(i);
   assign j_a    = ADDR_W'(j);
   assign k_a    = ADDR_W'(k);
   assign n_a    = ADDR_W'(N);
   assign a_addr = A_BASE + i_a * n_a + k_a;
   assign b_addr = B_BASE + k_a * n_a + j_a;
   assign c_addr = C_BASE + i_a * n_a + j_a;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state      = state;
      inc_k           = 1'b0;
      inc_ij          = 1'b0;
      clr             = 1'b0;
      bus.address     = '0;
      bus.write_en    = 1'b0;
      bus.rd_valid    = 1'b0;
      bus.operand_sel = 1'b0;
      bus.acc_clear   = 1'b0;
      bus.k_last      = 1'b0;
      bus.busy        = (state != IDLE);
      bus.done        = 1'b0;

      case (state)
         IDLE: begin
            if (bus.start) begin
               clr        = 1'b1;
               next_state = RD_A;
            end
         end
         RD_A: begin
            bus.address   = a_addr;
            bus.rd_valid  = 1'b1;
            bus.acc_clear = (k == '0);
            if (!bus.stall) next_state = RD_B;
         end
         RD_B: begin
            bus.address     = b_addr;
            bus.rd_valid    = 1'b1;
            bus.operand_sel = 1'b1;
            bus.k_last      = k_at_last;
            if (!bus.stall) begin
               if (k_at_last) begin
                  next_state = WAIT_MAC;
               end else begin
                  inc_k      = 1'b1;
                  next_state = RD_A;
               end
            end
         end
         WAIT_MAC: begin
            if (bus.mac_done) next_state = WR_C;
         end
         // A stalled write keeps write_en and the address stable until accepted
         WR_C: begin
            bus.address  = c_addr;
            bus.write_en = 1'b1;
            if (!bus.stall) begin
               inc_ij     = 1'b1;
               next_state = ij_at_last ? DONE : RD_A;
            end
         end
         DONE: begin
            bus.done   = 1'b1;
            clr        = 1'b1;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_matmul_addr_seq.sv
// Self-checking bench for matmul_addr_seq: a phase-list reference model of the
// whole multiply is compared against the DUT every cycle under random stimulus.
module tb_matmul_addr_seq;
   import matmul_pkg::*;

   localparam int         N      = 4;
   localparam int         ADDR_W = 8;
   localparam logic [7:0] A_BASE = 8'h00;
   localparam logic [7:0] B_BASE = 8'h40;
   localparam logic [7:0] C_BASE = 8'h80;

   typedef struct {
      logic [7:0] addr;
      bit         we;
      bit         rd;
      bit         opSel;
      bit         accClr;
      bit         kLast;
      bit         isWait;
      bit         isDone;
   } phase_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   matmul_addr_seq_if #(.ADDR_W(ADDR_W)) bus ();

   matmul_addr_seq #(
      .N      (N),
      .ADDR_W (ADDR_W),
      .A_BASE (A_BASE),
      .B_BASE (B_BASE),
      .C_BASE (C_BASE)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int         checkCount = 0;
   int         failCount  = 0;
   phase_t     phases[$];
   logic [7:0] rdQ[$];
   logic [7:0] wrQ[$];
   int         busyCycles;
   int         doneCount;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Whole multiply as an ordered list of bus phases, straight from the matrix maths
   function automatic void buildPhases();
      phase_t p;
      phases.delete();
      for (int e = 0; e < N * N; e++) begin
         for (int kk = 0; kk < N; kk++) begin
            p        = '{default: 0};
            p.addr   = 8'(A_BASE + (e / N) * N + kk);
            p.rd     = 1;
            p.accClr = (kk == 0);
            phases.push_back(p);
            p        = '{default: 0};
            p.addr   = 8'(B_BASE + kk * N + (e % N));
            p.rd     = 1;
            p.opSel  = 1;
            p.kLast  = (kk == N - 1);
            phases.push_back(p);
         end
         p        = '{default: 0};
         p.isWait = 1;
         phases.push_back(p);
         p        = '{default: 0};
         p.addr   = 8'(C_BASE + e);
         p.we     = 1;
         phases.push_back(p);
      end
      p        = '{default: 0};
      p.isDone = 1;
      phases.push_back(p);
   endfunction

   task automatic checkCycle(input bit active, input int idx);
      logic [7:0] expAddr;
      logic [6:0] expFlags;
      logic [6:0] obsFlags;
      phase_t     p;
      expAddr  = 8'h00;
      expFlags = 7'b0;
      if (active) begin
         p        = phases[idx];
         expAddr  = (p.isWait || p.isDone) ? 8'h00 : p.addr;
         expFlags = {p.we, p.rd, p.opSel, p.accClr, p.kLast, 1'b1, p.isDone};
      end
      obsFlags = {bus.write_en, bus.rd_valid, bus.operand_sel, bus.acc_clear,
                  bus.k_last, bus.busy, bus.done};
      checkOutput($sformatf("address@phase%0d", idx), 32'(bus.address), 32'(expAddr));
      checkOutput($sformatf("flags{we,rd,sel,clr,klast,busy,done}@phase%0d", idx),
                  32'(obsFlags), 32'(expFlags));
   endtask

   // macWait: WAIT_MAC cycles before mac_done (0 = random); stallMode: 0 none, 1 directed, 2 random
   task automatic applyStimulus(input int macWait, input int stallMode, input bit abortAt83);
      int     idx        = 0;
      int     cycles     = 0;
      int     stallLeft  = 0;
      int     waitCycles = 0;
      bit     active;
      bit     seen44     = 0;
      bit     seen80     = 0;
      bit     doStall;
      bit     doMac;
      phase_t p;

      buildPhases();
      rdQ.delete();
      wrQ.delete();
      busyCycles = 0;
      doneCount  = 0;

      @(negedge clk);
      checkCycle(0, 0);
      bus.start    = 1'b1;
      bus.stall    = 1'b0;
      bus.mac_done = 1'b0;
      active       = 1;

      while (active && cycles < 4000) begin
         @(negedge clk);
         cycles++;
         checkCycle(1, idx);
         p = phases[idx];
         if (bus.busy) busyCycles++;
         if (bus.done) doneCount++;

         if (abortAt83 && p.we && p.addr == 8'h83) begin
            bus.start    = 1'b0;
            bus.stall    = 1'b0;
            bus.mac_done = 1'b0;
            #2 rst = 1'b1;
            #1;
            checkOutput("abort_write_en", 32'(bus.write_en), 32'd0);
            checkOutput("abort_address", 32'(bus.address), 32'd0);
            checkOutput("abort_busy", 32'(bus.busy), 32'd0);
            @(negedge clk);
            rst    = 1'b0;
            active = 0;
            break;
         end

         doStall = 0;
         if (stallMode == 1 && stallLeft == 0) begin
            if (p.rd && p.addr == 8'h44 && !seen44) begin
               seen44    = 1;
               stallLeft = 3;
            end else if (p.we && p.addr == 8'h80 && !seen80) begin
               seen80    = 1;
               stallLeft = 3;
            end
         end else if (stallMode == 2) begin
            doStall = ($urandom_range(3) == 0);
         end
         if (stallLeft > 0) begin
            doStall = 1;
            stallLeft--;
         end

         if (p.isWait) waitCycles++;
         if (macWait == 0) doMac = ($urandom_range(1) == 1);
         else              doMac = p.isWait && (waitCycles >= macWait);

         bus.start    = (stallMode == 2) ? ($urandom_range(4) == 0) : (idx == 3);
         bus.stall    = doStall;
         bus.mac_done = doMac;

         if (!doStall && p.rd) rdQ.push_back(bus.address);
         if (!doStall && p.we) wrQ.push_back(bus.address);

         if (p.isWait) begin
            if (doMac) begin
               idx++;
               waitCycles = 0;
            end
         end else if (p.isDone) begin
            active = 0;
         end else if (!doStall) begin
            idx++;
         end
      end

      if (active) checkOutput("timeout_sequence_incomplete", 32'd1, 32'd0);
      @(negedge clk);
      checkCycle(0, 0);
      bus.start    = 1'b0;
      bus.stall    = 1'b0;
      bus.mac_done = 1'b0;
   endtask

   initial begin
      logic [7:0] expRd00[8];
      logic [7:0] expRd12[8];
      expRd00 = '{8'h00, 8'h40, 8'h01, 8'h44, 8'h02, 8'h48, 8'h03, 8'h4C};
      expRd12 = '{8'h04, 8'h42, 8'h05, 8'h46, 8'h06, 8'h4A, 8'h07, 8'h4E};

      // Reset with start held high: reset must win
      rst          = 1'b1;
      bus.start    = 1'b1;
      bus.stall    = 1'b0;
      bus.mac_done = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checkCycle(0, 0);
      end
      rst       = 1'b0;
      bus.start = 1'b0;
      repeat (10) begin
         @(negedge clk);
         checkCycle(0, 0);
      end

      $display("[TB] run 1: no stalls, mac_done after 2 wait cycles");
      applyStimulus(2, 0, 0);
      checkOutput("rd_count", 32'(rdQ.size()), 32'd128);
      checkOutput("wr_count", 32'(wrQ.size()), 32'd16);
      if (rdQ.size() == 128) begin
         for (int n = 0; n < 8; n++) begin
            checkOutput($sformatf("elem00_rd%0d", n), 32'(rdQ[n]), 32'(expRd00[n]));
            checkOutput($sformatf("elem12_rd%0d", n), 32'(rdQ[48 + n]), 32'(expRd12[n]));
         end
      end
      if (wrQ.size() == 16) begin
         checkOutput("elem00_wr", 32'(wrQ[0]), 32'h80);
         checkOutput("elem12_wr", 32'(wrQ[6]), 32'h86);
      end
      checkOutput("busy_cycles_wait2", 32'(busyCycles), 32'd177);

      $display("[TB] run 2: no stalls, immediate mac_done");
      applyStimulus(1, 0, 0);
      checkOutput("wr_count", 32'(wrQ.size()), 32'd16);
      if (wrQ.size() == 16) begin
         for (int n = 0; n < 16; n++)
            checkOutput($sformatf("wr_addr%0d", n), 32'(wrQ[n]), 32'(8'h80 + n));
      end
      checkOutput("done_pulses", 32'(doneCount), 32'd1);
      checkOutput("busy_cycles", 32'(busyCycles), 32'd161);

      $display("[TB] run 3: directed stalls at 0x44 read and 0x80 write");
      applyStimulus(1, 1, 0);
      checkOutput("busy_cycles_stalled", 32'(busyCycles), 32'd167);
      checkOutput("stall_rd_count", 32'(rdQ.size()), 32'd128);
      if (rdQ.size() == 128) checkOutput("stall_rd3", 32'(rdQ[3]), 32'h44);
      if (wrQ.size() > 0)    checkOutput("stall_wr0", 32'(wrQ[0]), 32'h80);

      $display("[TB] run 4: random stall, mac_done and start");
      applyStimulus(0, 2, 0);
      checkOutput("random_done_pulses", 32'(doneCount), 32'd1);
      checkOutput("random_wr_count", 32'(wrQ.size()), 32'd16);

      $display("[TB] run 5: asynchronous reset during write of 0x83");
      applyStimulus(1, 0, 1);
      checkOutput("abort_wr_count", 32'(wrQ.size()), 32'd3);

      $display("[TB] run 6: restart after abort");
      applyStimulus(1, 0, 0);
      checkOutput("restart_rd_count", 32'(rdQ.size()), 32'd128);
      if (rdQ.size() > 0) checkOutput("restart_first_rd", 32'(rdQ[0]), 32'h00);
      checkOutput("restart_wr_count", 32'(wrQ.size()), 32'd16);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
